// File: rtl/seq_link_pkg.sv
// Shared definitions for the serial bit-stream link (transmitter and detector).
package seq_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  localparam logic [3:0] SYNC_PATTERN = 4'b1101;
  localparam int         SYNC_LEN     = 4;

  // Counter must hold the longest phase: payload, gap or sync marker.
  function automatic int cnt_width(input int w, input int g);
    int m;
    m = w;
    if (g > m) m = g;
    if (SYNC_LEN > m) m = SYNC_LEN;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_tx_bitcnt.sv
// Loadable down counter with zero flag; saturates at zero instead of wrapping.
module seq_tx_bitcnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          dec,
  output logic [CW-1:0] cnt_nxt,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld)
      cnt_d = ld_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_nxt = cnt_d;
  assign zero    = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: shifts words out MSB-first with optional idle gap bits.
// Define SEQ_TX_PREAMBLE_EN to prefix every frame with the SYNC_PATTERN marker.
module seq_pattern_tx
  import seq_link_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int GAP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW     = cnt_width(WIDTH, GAP_BITS);
  localparam bit NO_GAP = (GAP_BITS == 0);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             cnt_ld, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_ld_val, cnt_nxt;
  logic             hs;

  seq_tx_bitcnt #(.CW(CW)) u_bitcnt (
    .clk     (clk),
    .rst     (rst),
    .ld      (cnt_ld),
    .ld_val  (cnt_ld_val),
    .dec     (cnt_dec),
    .cnt_nxt (cnt_nxt),
    .zero    (cnt_zero)
  );

  // Ready in idle and on the last cycle of a frame, so frames can abut.
  assign in_ready = !rst && ((state_q == ST_IDLE) ||
                             (cnt_zero && ((state_q == ST_GAP) ||
                                           (NO_GAP && (state_q == ST_DATA)))));
  assign hs = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    cnt_ld       = 1'b0;
    cnt_ld_val   = '0;
    cnt_dec      = 1'b0;

    case (state_q)
`ifdef SEQ_TX_PREAMBLE_EN
      ST_PRE: begin
        dout_valid_d = 1'b1;
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
          dout_d  = SYNC_PATTERN[cnt_nxt[1:0]];
        end else begin
          state_d    = ST_DATA;
          cnt_ld     = 1'b1;
          cnt_ld_val = CW'(WIDTH - 1);
          dout_d     = sh_q[WIDTH-1];
          sh_d       = sh_q << 1;
        end
      end
`endif
      ST_DATA: begin
        if (!cnt_zero) begin
          cnt_dec      = 1'b1;
          dout_valid_d = 1'b1;
          dout_d       = sh_q[WIDTH-1];
          sh_d         = sh_q << 1;
        end else if (!NO_GAP) begin
          state_d    = ST_GAP;
          cnt_ld     = 1'b1;
          cnt_ld_val = CW'(GAP_BITS - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!cnt_zero) cnt_dec = 1'b1;
        else           state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A handshake only happens in idle or on a frame's final cycle, so it overrides.
    if (hs) begin
      cnt_ld       = 1'b1;
      dout_valid_d = 1'b1;
`ifdef SEQ_TX_PREAMBLE_EN
      state_d    = ST_PRE;
      cnt_ld_val = CW'(SYNC_LEN - 1);
      dout_d     = SYNC_PATTERN[SYNC_LEN-1];
      sh_d       = in_data;
`else
      state_d    = ST_DATA;
      cnt_ld_val = CW'(WIDTH - 1);
      dout_d     = in_data[WIDTH-1];
      sh_d       = in_data << 1;
`endif
    end

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DATA) && (cnt_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
